// File: rtl/call_sequencer.sv
// Program-counter sequencer: owns the PC, decodes per-cycle control ops and
// drives the instruction stack's call/return strobes with depth tracking.
module call_sequencer #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [2:0]            i_op,
   input  logic                  i_cond,
   input  logic [DATA_WIDTH-1:0] i_target,
   input  logic [DATA_WIDTH-1:0] i_stack,
   output logic [DATA_WIDTH-1:0] o_PC,
   output logic                  o_call,
   output logic                  o_rtrn,
   output logic [ADDR_WIDTH:0]   o_depth,
   output logic [1:0]            o_state,
   output logic                  o_ovf,
   output logic                  o_unf
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_RET_WAIT = 2'd1,
      S_HALT     = 2'd2,
      S_ERROR    = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_JUMP   = 3'd1,
      OP_BRANCH = 3'd2,
      OP_CALL   = 3'd3,
      OP_RTRN   = 3'd4,
      OP_HALT   = 3'd5
   } op_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                state;
   logic                  full;
   logic                  empty;
   logic                  run_act;
   logic [DATA_WIDTH-1:0] pc_inc;

   assign o_state = state;
   assign full    = (o_depth == DEPTH_MAX);
   assign empty   = (o_depth == '0);
   assign pc_inc  = o_PC + 1'b1;

   // Strobes must be valid while o_PC still holds the issuing PC, so they are
   // decoded combinationally; i_rst gating keeps them low during reset.
   always_comb begin
      run_act = i_rst && (state == S_RUN) && i_en;
      o_call  = run_act && (i_op == OP_CALL) && !full;
      o_rtrn  = run_act && (i_op == OP_RTRN) && !empty;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_PC    <= '0;
         o_depth <= '0;
         state   <= S_RUN;
         o_ovf   <= 1'b0;
         o_unf   <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (i_en) begin
                  case (i_op)
                     OP_JUMP:   o_PC <= i_target;
                     OP_BRANCH: o_PC <= i_cond ? i_target : pc_inc;
                     OP_CALL: begin
                        if (!full) begin
                           o_PC    <= i_target;
                           o_depth <= o_depth + 1'b1;
                        end else begin
                           o_ovf <= 1'b1;
                           state <= S_ERROR;
                        end
                     end
                     OP_RTRN: begin
                        if (!empty) begin
                           o_depth <= o_depth - 1'b1;
                           state   <= S_RET_WAIT;
                        end else begin
                           o_unf <= 1'b1;
                           state <= S_ERROR;
                        end
                     end
                     OP_HALT:   state <= S_HALT;
                     default:   o_PC <= pc_inc;
                  endcase
               end
            end
            // The stack presents the saved return address one edge after rtrn.
            S_RET_WAIT: begin
               o_PC  <= i_stack;
               state <= S_RUN;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_call_sequencer.sv
// Scoreboard bench for call_sequencer with a behavioural 16-deep return stack.
module tb_call_sequencer;

   localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3,
                          RTRN = 3'd4, HALT = 3'd5;
   localparam logic [1:0] RUN = 2'd0, RW = 2'd1, HLT = 2'd2, ERR = 2'd3;

   typedef struct packed {
      logic [15:0] pc;
      logic [4:0]  depth;
      logic [1:0]  st;
      logic        call;
      logic        rtrn;
      logic        ovf;
      logic        unf;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [2:0]  op = '0;
   logic        cond = 1'b0;
   logic [15:0] tgt = '0;
   logic [15:0] stack_out = '0;
   logic [15:0] pc;
   logic        call, rtrn, ovf, unf;
   logic [4:0]  depth;
   logic [1:0]  st;

   obs_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad = 0;

   logic [15:0] mem [0:15];
   logic [4:0]  sp = '0;

   always #5 clk = ~clk;

   call_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_op(op), .i_cond(cond),
      .i_target(tgt), .i_stack(stack_out), .o_PC(pc), .o_call(call),
      .o_rtrn(rtrn), .o_depth(depth), .o_state(st), .o_ovf(ovf), .o_unf(unf)
   );

   // Return stack: push PC+1 on call, present popped value after rtrn edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp <= '0;
      end else if (call) begin
         mem[sp[3:0]] <= pc + 16'd1;
         sp <= sp + 5'd1;
      end else if (rtrn) begin
         stack_out <= mem[4'(sp - 5'd1)];
         sp <= sp - 5'd1;
      end
   end

   // Monitor: one observation per cycle, sampled at the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         obs_t  e, a;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = '{pc, depth, st, call, rtrn, ovf, unf};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s: got pc=%h depth=%0d st=%0d call=%b rtrn=%b ovf=%b unf=%b, want pc=%h depth=%0d st=%0d call=%b rtrn=%b ovf=%b unf=%b",
                     t, a.pc, a.depth, a.st, a.call, a.rtrn, a.ovf, a.unf,
                     e.pc, e.depth, e.st, e.call, e.rtrn, e.ovf, e.unf);
         end
      end
   end

   task automatic step(input string t, input logic r, input logic e,
                       input logic [2:0] o, input logic c, input logic [15:0] g,
                       input logic [15:0] xpc, input logic [4:0] xd,
                       input logic [1:0] xst, input logic xc, input logic xr,
                       input logic xo, input logic xu);
      @(posedge clk);
      #1;
      rst = r; en = e; op = o; cond = c; tgt = g;
      exp_q.push_back('{xpc, xd, xst, xc, xr, xo, xu});
      tag_q.push_back(t);
   endtask

   initial begin
      // reset state, then enable gating
      step("reset",     0, 0, NOP,  0, 16'h0,   16'h0, 0, RUN, 0, 0, 0, 0);
      step("en0_call",  1, 0, CALL, 0, 16'h9,   16'h0, 0, RUN, 0, 0, 0, 0);
      step("en0_jmp",   1, 0, JMP,  0, 16'h9,   16'h0, 0, RUN, 0, 0, 0, 0);
      step("en0_nop",   1, 0, NOP,  0, 16'h0,   16'h0, 0, RUN, 0, 0, 0, 0);
      step("nop0",      1, 1, NOP,  0, 16'h0,   16'h0, 0, RUN, 0, 0, 0, 0);
      step("nop1",      1, 1, NOP,  0, 16'h0,   16'h1, 0, RUN, 0, 0, 0, 0);
      step("nop2",      1, 1, NOP,  0, 16'h0,   16'h2, 0, RUN, 0, 0, 0, 0);
      // single call/return
      step("jmp10",     1, 1, JMP,  0, 16'd10,  16'h3, 0, RUN, 0, 0, 0, 0);
      step("call40",    1, 1, CALL, 0, 16'h40,  16'd10, 0, RUN, 1, 0, 0, 0);
      step("rtrn1",     1, 1, RTRN, 0, 16'h0,   16'h40, 1, RUN, 0, 1, 0, 0);
      step("retwait",   1, 1, CALL, 0, 16'h99,  16'h40, 0, RW,  0, 0, 0, 0);
      step("ret_pc",    1, 0, NOP,  0, 16'h0,   16'd11, 0, RUN, 0, 0, 0, 0);
      // nested calls
      step("jmp_nest",  1, 1, JMP,  0, 16'h10,  16'd11, 0, RUN, 0, 0, 0, 0);
      for (int k = 1; k <= 9; k++)
         step("ncall", 1, 1, CALL, 0, 16'(16 * (k + 1)), 16'(16 * k), 5'(k - 1), RUN, 1, 0, 0, 0);
      for (int j = 0; j < 9; j++) begin
         step("nrtrn", 1, 1, RTRN, 0, 16'h0,
              (j == 0) ? 16'hA0 : 16'(16 * (10 - j) + 1), 5'(9 - j), RUN, 0, 1, 0, 0);
         step("nwait", 1, 0, NOP, 0, 16'h0,
              (j == 0) ? 16'hA0 : 16'(16 * (10 - j) + 1), 5'(8 - j), RW, 0, 0, 0, 0);
      end
      step("nest_end",  1, 0, NOP,  0, 16'h0,   16'h11, 0, RUN, 0, 0, 0, 0);
      // underflow
      step("unf_try",   1, 1, RTRN, 0, 16'h0,   16'h11, 0, RUN, 0, 0, 0, 0);
      step("unf_err",   1, 1, JMP,  0, 16'h55,  16'h11, 0, ERR, 0, 0, 0, 1);
      step("unf_hold",  1, 1, NOP,  0, 16'h0,   16'h11, 0, ERR, 0, 0, 0, 1);
      step("unf_rst",   0, 0, NOP,  0, 16'h0,   16'h0, 0, RUN, 0, 0, 0, 0);
      // overflow
      for (int k = 0; k < 16; k++)
         step("ocall", 1, 1, CALL, 0, 16'(k + 1), 16'(k), 5'(k), RUN, 1, 0, 0, 0);
      step("ovf_try",   1, 1, CALL, 0, 16'h77,  16'd16, 16, RUN, 0, 0, 0, 0);
      step("ovf_err",   1, 1, JMP,  0, 16'h5,   16'd16, 16, ERR, 0, 0, 1, 0);
      step("ovf_hold",  1, 1, RTRN, 0, 16'h0,   16'd16, 16, ERR, 0, 0, 1, 0);
      step("ovf_rst",   0, 1, CALL, 0, 16'h0,   16'h0, 0, RUN, 0, 0, 0, 0);
      // branch and wrap
      step("br_taken",  1, 1, BR,   1, 16'h20,  16'h0, 0, RUN, 0, 0, 0, 0);
      step("br_not",    1, 1, BR,   0, 16'h50,  16'h20, 0, RUN, 0, 0, 0, 0);
      step("jmp_ffff",  1, 1, JMP,  0, 16'hFFFF, 16'h21, 0, RUN, 0, 0, 0, 0);
      step("wrap_nop",  1, 1, NOP,  0, 16'h0,   16'hFFFF, 0, RUN, 0, 0, 0, 0);
      // halt absorbs
      step("halt",      1, 1, HALT, 0, 16'h0,   16'h0, 0, RUN, 0, 0, 0, 0);
      step("halt_call", 1, 1, CALL, 0, 16'h30,  16'h0, 0, HLT, 0, 0, 0, 0);
      step("halt_jmp",  1, 1, JMP,  0, 16'h30,  16'h0, 0, HLT, 0, 0, 0, 0);
      step("halt_rtrn", 1, 1, RTRN, 0, 16'h0,   16'h0, 0, HLT, 0, 0, 0, 0);
      // async reset while in RET_WAIT, applied between clock edges
      step("rst2",      0, 0, NOP,  0, 16'h0,   16'h0, 0, RUN, 0, 0, 0, 0);
      step("call60",    1, 1, CALL, 0, 16'h60,  16'h0, 0, RUN, 1, 0, 0, 0);
      step("rtrn60",    1, 1, RTRN, 0, 16'h0,   16'h60, 1, RUN, 0, 1, 0, 0);
      step("rw_rst",    0, 1, CALL, 0, 16'h70,  16'h0, 0, RUN, 0, 0, 0, 0);
      step("post_rst",  1, 1, NOP,  0, 16'h0,   16'h0, 0, RUN, 0, 0, 0, 0);
      step("post_nop",  1, 0, NOP,  0, 16'h0,   16'h1, 0, RUN, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
